// File: rtl/mips_single_cycle_cpu.sv
// mips_single_cycle_cpu: single-cycle 32-bit MIPS subset core.
// Holds only the PC plus decode/execute logic; instruction memory, data
// memory and the register file are external and read combinationally.
// Optional feature macro: JUMP_LINK_EN (adds jal and jr).
module mips_single_cycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_rd,
    output logic [31:0] data_memory_a,
    input  logic [31:0] data_memory_rd,
    output logic        data_memory_we,
    output logic [31:0] data_memory_wd,
    output logic [4:0]  register_a1,
    output logic [4:0]  register_a2,
    input  logic [31:0] register_rd1,
    input  logic [31:0] register_rd2,
    output logic [4:0]  register_a3,
    output logic        register_we3,
    output logic [31:0] register_wd3
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Sign-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] sign_ext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic [31:0] imm_sext_s;
    logic [31:0] imm_zext_s;
    logic [31:0] branch_target_s;
    logic [31:0] jump_target_s;
    logic [31:0] alu_result_s;
    logic [31:0] wd_s;
    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  a3_s;
    logic        reg_we_s;
    logic        mem_we_s;
    logic        nop_word_s;

    assign opcode_s        = instruction_memory_rd[31:26];
    assign rs_s            = instruction_memory_rd[25:21];
    assign rt_s            = instruction_memory_rd[20:16];
    assign rd_s            = instruction_memory_rd[15:11];
    assign funct_s         = instruction_memory_rd[5:0];
    assign nop_word_s      = (instruction_memory_rd == 32'h0000_0000);
    assign imm_sext_s      = sign_ext(instruction_memory_rd[15:0]);
    assign imm_zext_s      = {16'h0000, instruction_memory_rd[15:0]};
    assign pc_plus4_s      = pc_r + 32'd4;
    assign branch_target_s = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
    assign jump_target_s   = {pc_plus4_s[31:28], instruction_memory_rd[25:0], 2'b00};

    // PC register: loads RESET_PC asynchronously, otherwise commits next PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Decode and execute the current instruction; unknown encodings fall through as NOP.
    always_comb begin
        reg_we_s     = 1'b0;
        mem_we_s     = 1'b0;
        a3_s         = 5'd0;
        wd_s         = 32'h0000_0000;
        alu_result_s = 32'h0000_0000;
        next_pc_s    = pc_plus4_s;
        case (opcode_s)
            OP_RTYPE: begin
                a3_s = rd_s;
                case (funct_s)
                    FN_ADD: begin
                        alu_result_s = register_rd1 + register_rd2;
                        reg_we_s     = 1'b1;
                    end
                    FN_SUB: begin
                        alu_result_s = register_rd1 - register_rd2;
                        reg_we_s     = 1'b1;
                    end
                    FN_AND: begin
                        alu_result_s = register_rd1 & register_rd2;
                        reg_we_s     = 1'b1;
                    end
                    FN_OR: begin
                        alu_result_s = register_rd1 | register_rd2;
                        reg_we_s     = 1'b1;
                    end
                    FN_SLT: begin
                        alu_result_s = ($signed(register_rd1) < $signed(register_rd2)) ?
                                       32'd1 : 32'd0;
                        reg_we_s     = 1'b1;
                    end
`ifdef JUMP_LINK_EN
                    FN_JR: begin
                        next_pc_s = register_rd1;
                    end
`endif
                    default: begin
                        reg_we_s = 1'b0;
                    end
                endcase
                wd_s = alu_result_s;
            end
            OP_ADDI: begin
                a3_s         = rt_s;
                alu_result_s = register_rd1 + imm_sext_s;
                wd_s         = alu_result_s;
                reg_we_s     = 1'b1;
            end
            OP_ANDI: begin
                a3_s         = rt_s;
                alu_result_s = register_rd1 & imm_zext_s;
                wd_s         = alu_result_s;
                reg_we_s     = 1'b1;
            end
            OP_LW: begin
                a3_s         = rt_s;
                alu_result_s = register_rd1 + imm_sext_s;
                wd_s         = data_memory_rd;
                reg_we_s     = 1'b1;
            end
            OP_SW: begin
                alu_result_s = register_rd1 + imm_sext_s;
                mem_we_s     = 1'b1;
            end
            OP_BEQ: begin
                alu_result_s = register_rd1 - register_rd2;
                if (register_rd1 == register_rd2) begin
                    next_pc_s = branch_target_s;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            OP_BNE: begin
                alu_result_s = register_rd1 - register_rd2;
                if (register_rd1 != register_rd2) begin
                    next_pc_s = branch_target_s;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            OP_J: begin
                next_pc_s = jump_target_s;
            end
`ifdef JUMP_LINK_EN
            OP_JAL: begin
                a3_s      = 5'd31;
                wd_s      = pc_plus4_s;
                reg_we_s  = 1'b1;
                next_pc_s = jump_target_s;
            end
`endif
            default: begin
                reg_we_s = 1'b0;
            end
        endcase
    end

    assign instruction_memory_a = pc_r;
    assign data_memory_a        = alu_result_s;
    assign data_memory_wd       = register_rd2;
    // Writes are gated by reset so an instruction interrupted by reset never commits.
    assign data_memory_we       = mem_we_s & rst_n;
    assign register_a1          = rs_s;
    assign register_a2          = rt_s;
    assign register_a3          = a3_s;
    assign register_we3         = reg_we_s & ~nop_word_s & (a3_s != 5'd0) & rst_n;
    assign register_wd3         = wd_s;

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Self-checking bench for mips_single_cycle_cpu with behavioural memories
// and an instruction-level reference model.
module tb_mips_single_cycle_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_memory_a;
    logic [31:0] instruction_memory_rd;
    logic [31:0] data_memory_a;
    logic [31:0] data_memory_rd;
    logic        data_memory_we;
    logic [31:0] data_memory_wd;
    logic [4:0]  register_a1;
    logic [4:0]  register_a2;
    logic [31:0] register_rd1;
    logic [31:0] register_rd2;
    logic [4:0]  register_a3;
    logic        register_we3;
    logic [31:0] register_wd3;

    logic [31:0] imem [1024];
    logic [31:0] dmem [256];
    logic [31:0] rf   [32];
    logic [31:0] m_rf [32];
    logic [31:0] m_mem[256];
    logic [31:0] m_pc;
    logic [31:0] prog [$];

    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_mwe;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;

    int checks = 0;
    int errors = 0;

    mips_single_cycle_cpu dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .instruction_memory_a  (instruction_memory_a),
        .instruction_memory_rd (instruction_memory_rd),
        .data_memory_a         (data_memory_a),
        .data_memory_rd        (data_memory_rd),
        .data_memory_we        (data_memory_we),
        .data_memory_wd        (data_memory_wd),
        .register_a1           (register_a1),
        .register_a2           (register_a2),
        .register_rd1          (register_rd1),
        .register_rd2          (register_rd2),
        .register_a3           (register_a3),
        .register_we3          (register_we3),
        .register_wd3          (register_wd3)
    );

    always #5 clk = ~clk;

    assign instruction_memory_rd = imem[instruction_memory_a[11:2]];
    assign data_memory_rd        = dmem[data_memory_a[9:2]];
    assign register_rd1          = rf[register_a1];
    assign register_rd2          = rf[register_a2];

    // External register file and data memory: plain storage, cleared while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
            for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
        end else begin
            if (register_we3) rf[register_a3] <= register_wd3;
            if (data_memory_we) dmem[data_memory_a[9:2]] <= data_memory_wd;
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] gen_rand();
        logic [4:0] s, t, d;
        int k;
        k = $urandom_range(0, 11);
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case (k)
            0:  return enc_r(6'h20, s, t, d);
            1:  return enc_r(6'h22, s, t, d);
            2:  return enc_r(6'h24, s, t, d);
            3:  return enc_r(6'h25, s, t, d);
            4:  return enc_r(6'h2A, s, t, d);
            5:  return enc_i(6'h08, s, t, 16'($urandom));
            6:  return enc_i(6'h0C, s, t, 16'($urandom));
            7:  return enc_i(6'h23, s, t, 16'($urandom));
            8:  return enc_i(6'h2B, s, t, 16'($urandom));
            9:  return enc_i(6'h04, s, t, 16'($urandom_range(0, 3)));
            10: return enc_i(6'h05, s, t, 16'($urandom_range(0, 3)));
            default: return enc_r(6'h3F, s, t, d);
        endcase
    endfunction

    // Reference model: executes one instruction at m_pc and publishes its expected effects.
    task automatic model_exec();
        logic [31:0] ins, rs_v, rt_v, se, pc4, addr, nxt;
        ins  = imem[m_pc[11:2]];
        rs_v = m_rf[ins[25:21]];
        rt_v = m_rf[ins[20:16]];
        se   = {{16{ins[15]}}, ins[15:0]};
        pc4  = m_pc + 32'd4;
        addr = rs_v + se;
        nxt  = pc4;
        e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'h0; e_mwe = 1'b0; e_ma = 32'h0; e_mwd = 32'h0;
        case (ins[31:26])
            6'h00: begin
                e_a3 = ins[15:11];
                case (ins[5:0])
                    6'h20: begin e_we = 1'b1; e_wd = rs_v + rt_v; end
                    6'h22: begin e_we = 1'b1; e_wd = rs_v - rt_v; end
                    6'h24: begin e_we = 1'b1; e_wd = rs_v & rt_v; end
                    6'h25: begin e_we = 1'b1; e_wd = rs_v | rt_v; end
                    6'h2A: begin e_we = 1'b1; e_wd = ($signed(rs_v) < $signed(rt_v)) ? 32'd1 : 32'd0; end
`ifdef JUMP_LINK_EN
                    6'h08: nxt = rs_v;
`endif
                    default: ;
                endcase
            end
            6'h08: begin e_we = 1'b1; e_a3 = ins[20:16]; e_wd = addr; end
            6'h0C: begin e_we = 1'b1; e_a3 = ins[20:16]; e_wd = rs_v & {16'h0, ins[15:0]}; end
            6'h23: begin e_we = 1'b1; e_a3 = ins[20:16]; e_wd = m_mem[addr[9:2]]; e_ma = addr; end
            6'h2B: begin e_mwe = 1'b1; e_ma = addr; e_mwd = rt_v; end
            6'h04: if (rs_v == rt_v) nxt = pc4 + (se << 2);
            6'h05: if (rs_v != rt_v) nxt = pc4 + (se << 2);
            6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
`ifdef JUMP_LINK_EN
            6'h03: begin e_we = 1'b1; e_a3 = 5'd31; e_wd = pc4; nxt = {pc4[31:28], ins[25:0], 2'b00}; end
`endif
            default: ;
        endcase
        if (e_a3 == 5'd0) e_we = 1'b0;
        if (e_we) m_rf[e_a3] = e_wd;
        if (e_mwe) m_mem[e_ma[9:2]] = e_mwd;
        m_pc = nxt;
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    endtask

    task automatic start_prog();
        for (int i = 0; i < 1024; i++) imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_cycle();
        model_exec();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (instruction_memory_a !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", instruction_memory_a, 32'h0); end
        checks++; if (register_we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b want 0", register_we3); end
        imem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'd4);
        #1;
        checks++; if (data_memory_we !== 1'b0) begin errors++; $display("FAIL reset_dmwe got %b want 0", data_memory_we); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        #1;
        checks++; if (instruction_memory_a !== 32'h0) begin errors++; $display("FAIL release_pc0 got %h want 0", instruction_memory_a); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h4) begin errors++; $display("FAIL release_pc4 got %h want 4", instruction_memory_a); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h8) begin errors++; $display("FAIL release_pc8 got %h want 8", instruction_memory_a); end
        imem[2] = enc_i(6'h2B, 5'd0, 5'd0, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (instruction_memory_a !== 32'h0) begin errors++; $display("FAIL midreset_pc got %h want 0", instruction_memory_a); end
        checks++; if (data_memory_we !== 1'b0) begin errors++; $display("FAIL midreset_dmwe got %b want 0", data_memory_we); end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        prog.delete();
        prog.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        prog.push_back(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        prog.push_back(enc_r(6'h20, 5'd1, 5'd2, 5'd3));
        prog.push_back(enc_r(6'h22, 5'd2, 5'd1, 5'd4));
        prog.push_back(enc_r(6'h2A, 5'd2, 5'd1, 5'd5));
        start_prog();
        repeat (5) run_cycle();
        checks++; if (rf[3] !== 32'd2) begin errors++; $display("FAIL arith_add got %h want %h", rf[3], 32'd2); end
        checks++; if (rf[4] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL arith_sub got %h want %h", rf[4], 32'hFFFF_FFF8); end
        checks++; if (rf[5] !== 32'd1) begin errors++; $display("FAIL arith_slt got %h want %h", rf[5], 32'd1); end
        for (int i = 1; i < 6; i++) begin
            checks++; if (rf[i] !== m_rf[i]) begin errors++; $display("FAIL arith_reg%0d got %h want %h", i, rf[i], m_rf[i]); end
        end
    endtask

    task automatic test_memory();
        prog.delete();
        prog.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'h1234));
        prog.push_back(enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
        prog.push_back(enc_i(6'h23, 5'd0, 5'd2, 16'd8));
        start_prog();
        run_cycle();
        checks++; if (data_memory_a !== 32'd8) begin errors++; $display("FAIL sw_addr got %h want %h", data_memory_a, 32'd8); end
        checks++; if (data_memory_we !== 1'b1) begin errors++; $display("FAIL sw_we got %b want 1", data_memory_we); end
        checks++; if (data_memory_wd !== 32'h1234) begin errors++; $display("FAIL sw_wd got %h want %h", data_memory_wd, 32'h1234); end
        run_cycle();
        run_cycle();
        checks++; if (rf[2] !== 32'h1234) begin errors++; $display("FAIL lw_data got %h want %h", rf[2], 32'h1234); end
    endtask

    task automatic test_branches();
        prog.delete();
        repeat (4) prog.push_back(32'h0);
        prog.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
        prog.push_back(32'h0);
        prog.push_back(32'h0);
        prog.push_back(enc_i(6'h05, 5'd0, 5'd0, 16'd2));
        prog.push_back({6'h02, 26'h40});
        start_prog();
        repeat (4) run_cycle();
        checks++; if (instruction_memory_a !== 32'h10) begin errors++; $display("FAIL br_pre got %h want %h", instruction_memory_a, 32'h10); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h1C) begin errors++; $display("FAIL beq_taken got %h want %h", instruction_memory_a, 32'h1C); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h20) begin errors++; $display("FAIL bne_nottaken got %h want %h", instruction_memory_a, 32'h20); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h100) begin errors++; $display("FAIL j_target got %h want %h", instruction_memory_a, 32'h100); end
    endtask

    task automatic test_zero_protect();
        prog.delete();
        prog.push_back(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        prog.push_back(32'hFC00_0000);
        prog.push_back(32'h0);
        start_prog();
        checks++; if (register_we3 !== 1'b0) begin errors++; $display("FAIL zero_we3 got %b want 0", register_we3); end
        run_cycle();
        checks++; if (rf[0] !== 32'h0) begin errors++; $display("FAIL zero_reg got %h want 0", rf[0]); end
        checks++; if ((register_we3 | data_memory_we) !== 1'b0) begin errors++; $display("FAIL undef_we got %b/%b want 0/0", register_we3, data_memory_we); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h8) begin errors++; $display("FAIL undef_pc got %h want %h", instruction_memory_a, 32'h8); end
        checks++; if (register_we3 !== 1'b0) begin errors++; $display("FAIL nopword_we3 got %b want 0", register_we3); end
    endtask

    task automatic test_jump_link();
        prog.delete();
        repeat (8) prog.push_back(32'h0);
        prog.push_back({6'h03, 26'h10});
        prog.push_back(enc_r(6'h08, 5'd31, 5'd0, 5'd0));
        repeat (6) prog.push_back(32'h0);
        prog.push_back(enc_r(6'h08, 5'd31, 5'd0, 5'd0));
        start_prog();
        repeat (8) run_cycle();
        checks++; if (instruction_memory_a !== 32'h20) begin errors++; $display("FAIL jal_pre got %h want %h", instruction_memory_a, 32'h20); end
        run_cycle();
`ifdef JUMP_LINK_EN
        checks++; if (instruction_memory_a !== 32'h40) begin errors++; $display("FAIL jal_pc got %h want %h", instruction_memory_a, 32'h40); end
        checks++; if (rf[31] !== 32'h24) begin errors++; $display("FAIL jal_link got %h want %h", rf[31], 32'h24); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h24) begin errors++; $display("FAIL jr_pc got %h want %h", instruction_memory_a, 32'h24); end
`else
        checks++; if (instruction_memory_a !== 32'h24) begin errors++; $display("FAIL jal_nop_pc got %h want %h", instruction_memory_a, 32'h24); end
        checks++; if (rf[31] !== 32'h0) begin errors++; $display("FAIL jal_nop_link got %h want 0", rf[31]); end
        checks++; if (register_we3 !== 1'b0) begin errors++; $display("FAIL jr_nop_we3 got %b want 0", register_we3); end
        run_cycle();
        checks++; if (instruction_memory_a !== 32'h28) begin errors++; $display("FAIL jr_nop_pc got %h want %h", instruction_memory_a, 32'h28); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] pc_exp;
        prog.delete();
        for (int i = 0; i < 1024; i++) prog.push_back(gen_rand());
        start_prog();
        for (int c = 0; c < 150; c++) begin
            pc_exp = m_pc;
            model_exec();
            checks++; if (instruction_memory_a !== pc_exp) begin errors++; $display("FAIL rnd_pc c%0d got %h want %h", c, instruction_memory_a, pc_exp); end
            checks++; if (register_we3 !== e_we) begin errors++; $display("FAIL rnd_we3 c%0d got %b want %b", c, register_we3, e_we); end
            if (e_we) begin
                checks++; if ({register_a3, register_wd3} !== {e_a3, e_wd}) begin errors++; $display("FAIL rnd_wb c%0d got %0d:%h want %0d:%h", c, register_a3, register_wd3, e_a3, e_wd); end
            end
            checks++; if (data_memory_we !== e_mwe) begin errors++; $display("FAIL rnd_dmwe c%0d got %b want %b", c, data_memory_we, e_mwe); end
            if (e_mwe) begin
                checks++; if ({data_memory_a, data_memory_wd} !== {e_ma, e_mwd}) begin errors++; $display("FAIL rnd_st c%0d got %h:%h want %h:%h", c, data_memory_a, data_memory_wd, e_ma, e_mwd); end
            end
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 32; i++) begin
            checks++; if (rf[i] !== m_rf[i]) begin errors++; $display("FAIL rnd_rf%0d got %h want %h", i, rf[i], m_rf[i]); end
        end
        for (int i = 0; i < 256; i++) begin
            checks++; if (dmem[i] !== m_mem[i]) begin errors++; $display("FAIL rnd_mem%0d got %h want %h", i, dmem[i], m_mem[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_arith();
        test_memory();
        test_branches();
        test_zero_protect();
        test_jump_link();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
